// File: rtl/vram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter_if
// Brief    : GPU fetch, CPU bridge and VRAM port bundle for vram_arbiter.
// Revision : 1.0
// ============================================================================
interface vram_arbiter_if;
  logic        gpu_req_i;
  logic [11:0] gpu_addr_i;
  logic        gpu_gnt_o;
  logic        gpu_rvalid_o;
  logic [7:0]  gpu_rdata_o;

  logic        cpu_wr_i;
  logic [11:0] cpu_waddr_i;
  logic [7:0]  cpu_wdata_i;
  logic        cpu_wfull_o;
  logic        cpu_rd_i;
  logic [11:0] cpu_raddr_i;
  logic        cpu_rbusy_o;
  logic        cpu_rdone_o;
  logic [7:0]  cpu_rdata_o;

  logic        vram_en_o;
  logic        vram_we_o;
  logic [11:0] vram_addr_o;
  logic [7:0]  vram_wdata_o;
  logic [7:0]  vram_rdata_i;

  modport slave (
    input  gpu_req_i, gpu_addr_i,
    input  cpu_wr_i, cpu_waddr_i, cpu_wdata_i, cpu_rd_i, cpu_raddr_i,
    input  vram_rdata_i,
    output gpu_gnt_o, gpu_rvalid_o, gpu_rdata_o,
    output cpu_wfull_o, cpu_rbusy_o, cpu_rdone_o, cpu_rdata_o,
    output vram_en_o, vram_we_o, vram_addr_o, vram_wdata_o
  );

  modport master (
    output gpu_req_i, gpu_addr_i,
    output cpu_wr_i, cpu_waddr_i, cpu_wdata_i, cpu_rd_i, cpu_raddr_i,
    output vram_rdata_i,
    input  gpu_gnt_o, gpu_rvalid_o, gpu_rdata_o,
    input  cpu_wfull_o, cpu_rbusy_o, cpu_rdone_o, cpu_rdata_o,
    input  vram_en_o, vram_we_o, vram_addr_o, vram_wdata_o
  );
endinterface
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Brief    : Single-port VRAM arbiter, GPU priority with bounded CPU starvation.
// Revision : 1.0
// ============================================================================
module vram_arbiter #(
  parameter int WR_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT  = 8
) (
  input  wire logic     clk_gpu,
  input  wire logic     rst,
  vram_arbiter_if.slave bus
);

  localparam int c_PTR_W = (WR_FIFO_DEPTH > 1) ? $clog2(WR_FIFO_DEPTH) : 1;
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_STV_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [11:0]        c_VRAM_SIZE  = 12'h900;
  localparam logic [c_CNT_W-1:0] c_FIFO_DEPTH = c_CNT_W'(WR_FIFO_DEPTH);
  localparam logic [c_STV_W-1:0] c_STARVE_MAX = c_STV_W'(STARVE_LIMIT);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_PEND = 2'd1;
  localparam logic [1:0] c_ST_DATA = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [11:0]        raddr_q, raddr_d;
  logic [11:0]        fifo_addr_q [WR_FIFO_DEPTH];
  logic [11:0]        fifo_addr_d [WR_FIFO_DEPTH];
  logic [7:0]         fifo_data_q [WR_FIFO_DEPTH];
  logic [7:0]         fifo_data_d [WR_FIFO_DEPTH];
  logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_CNT_W-1:0] count_q, count_d;
  logic [c_STV_W-1:0] starve_q, starve_d;
  logic               gpu_rvalid_q, gpu_rvalid_d;
  logic               gpu_oob_q, gpu_oob_d;
  logic               cpu_rdone_q, cpu_rdone_d;
  logic [7:0]         cpu_rdata_q, cpu_rdata_d;

  logic        fifo_empty, fifo_full, push, pop;
  logic        rd_pending, rd_in_data, rd_busy, cpu_pending;
  logic        gpu_win, wr_win, rd_win;
  logic [11:0] head_addr;
  logic [7:0]  head_data;
  logic        vram_en, vram_we;
  logic [11:0] vram_addr;
  logic [7:0]  vram_wdata;

  // Arbitration: grants are masked while reset is asserted so every output is 0.
  always_comb begin
    fifo_empty  = (count_q == '0);
    fifo_full   = (count_q == c_FIFO_DEPTH);
    head_addr   = fifo_addr_q[rd_ptr_q];
    head_data   = fifo_data_q[rd_ptr_q];
    cpu_pending = !fifo_empty || rd_pending;
    gpu_win     = !rst && bus.gpu_req_i && (starve_q < c_STARVE_MAX);
    wr_win      = !rst && !gpu_win && !fifo_empty;
    rd_win      = !rst && !gpu_win && fifo_empty && rd_pending;
    pop         = wr_win;
    push        = bus.cpu_wr_i && (!fifo_full || pop);
  end

  always_comb begin
    vram_en    = 1'b0;
    vram_we    = 1'b0;
    vram_addr  = '0;
    vram_wdata = '0;
    if (gpu_win) begin
      if (bus.gpu_addr_i < c_VRAM_SIZE) begin
        vram_en   = 1'b1;
        vram_addr = bus.gpu_addr_i;
      end
    end else if (wr_win) begin
      if (head_addr < c_VRAM_SIZE) begin
        vram_en    = 1'b1;
        vram_we    = 1'b1;
        vram_addr  = head_addr;
        vram_wdata = head_data;
      end
    end else if (rd_win) begin
      if (raddr_q < c_VRAM_SIZE) begin
        vram_en   = 1'b1;
        vram_addr = raddr_q;
      end
    end
  end

  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (push) begin
      fifo_addr_d[wr_ptr_q] = bus.cpu_waddr_i;
      fifo_data_d[wr_ptr_q] = bus.cpu_wdata_i;
      wr_ptr_d              = wr_ptr_q + c_PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + c_CNT_W'(1);
      2'b01:   count_d = count_q - c_CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Starvation counter only runs while the GPU keeps the CPU waiting.
  always_comb begin
    starve_d = starve_q;
    if (wr_win || rd_win || !cpu_pending) begin
      starve_d = '0;
    end else if (gpu_win && (starve_q < c_STARVE_MAX)) begin
      starve_d = starve_q + c_STV_W'(1);
    end
  end

  always_ff @(posedge clk_gpu or posedge rst) begin
    if (rst) begin
      state_q <= c_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    case (state_q)
      c_ST_IDLE: begin
        if (bus.cpu_rd_i) begin
          state_d = c_ST_PEND;
          raddr_d = bus.cpu_raddr_i;
        end
      end
      c_ST_PEND: begin
        if (rd_win) begin
          state_d = c_ST_DATA;
        end
      end
      c_ST_DATA: state_d = c_ST_IDLE;
      default:   state_d = c_ST_IDLE;
    endcase
  end

  always_comb begin
    rd_pending = (state_q == c_ST_PEND);
    rd_in_data = (state_q == c_ST_DATA);
    rd_busy    = (state_q != c_ST_IDLE);
  end

  // Read returns: VRAM data arrives the cycle after the grant; out-of-range reads return 0.
  always_comb begin
    gpu_rvalid_d = gpu_win;
    gpu_oob_d    = (bus.gpu_addr_i >= c_VRAM_SIZE);
    cpu_rdone_d  = rd_in_data;
    cpu_rdata_d  = cpu_rdata_q;
    if (rd_in_data) begin
      cpu_rdata_d = (raddr_q >= c_VRAM_SIZE) ? 8'h00 : bus.vram_rdata_i;
    end
  end

  always_ff @(posedge clk_gpu or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WR_FIFO_DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_q     <= '0;
      raddr_q      <= '0;
      gpu_rvalid_q <= 1'b0;
      gpu_oob_q    <= 1'b0;
      cpu_rdone_q  <= 1'b0;
      cpu_rdata_q  <= '0;
    end else begin
      fifo_addr_q  <= fifo_addr_d;
      fifo_data_q  <= fifo_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      starve_q     <= starve_d;
      raddr_q      <= raddr_d;
      gpu_rvalid_q <= gpu_rvalid_d;
      gpu_oob_q    <= gpu_oob_d;
      cpu_rdone_q  <= cpu_rdone_d;
      cpu_rdata_q  <= cpu_rdata_d;
    end
  end

  assign bus.gpu_gnt_o    = gpu_win;
  assign bus.gpu_rvalid_o = gpu_rvalid_q;
  assign bus.gpu_rdata_o  = (gpu_rvalid_q && !gpu_oob_q) ? bus.vram_rdata_i : 8'h00;
  assign bus.cpu_wfull_o  = fifo_full;
  assign bus.cpu_rbusy_o  = rd_busy;
  assign bus.cpu_rdone_o  = cpu_rdone_q;
  assign bus.cpu_rdata_o  = cpu_rdata_q;
  assign bus.vram_en_o    = vram_en;
  assign bus.vram_we_o    = vram_we;
  assign bus.vram_addr_o  = vram_addr;
  assign bus.vram_wdata_o = vram_wdata;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_arbiter
// Brief    : Directed bench for vram_arbiter with a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_vram_arbiter;
  localparam int WR_FIFO_DEPTH = 4;
  localparam int STARVE_LIMIT  = 8;

  logic clk_gpu;
  logic rst;
  int   n_chk;
  int   n_err;

  vram_arbiter_if bus ();

  vram_arbiter #(
    .WR_FIFO_DEPTH (WR_FIFO_DEPTH),
    .STARVE_LIMIT  (STARVE_LIMIT)
  ) u_dut (
    .clk_gpu (clk_gpu),
    .rst     (rst),
    .bus     (bus)
  );

  initial begin
    clk_gpu = 1'b0;
    forever #5 clk_gpu = ~clk_gpu;
  end

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 7 + 3);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Synchronous-read VRAM
  logic [7:0] vmem [0:4095];
  logic [7:0] vram_rd_r;
  assign bus.vram_rdata_i = vram_rd_r;

  initial begin
    for (int i = 0; i < 4096; i++) vmem[i] = pat(i);
    vram_rd_r = 8'h00;
    forever begin
      @(posedge clk_gpu);
      if (bus.vram_en_o === 1'b1) begin
        if (bus.vram_we_o) vmem[bus.vram_addr_o] <= bus.vram_wdata_o;
        else               vram_rd_r <= vmem[bus.vram_addr_o];
      end
    end
  end

  // Reference model: queue of posted writes, pending-read flag, expected memory image.
  logic [7:0]  mm [0:4095];
  logic [19:0] wq [$];
  logic        m_rd_pend, m_rvalid;
  logic [11:0] m_rd_addr;
  logic [7:0]  m_rd_val, m_gdata, m_cpu_rdata;
  int          m_flight, m_starve, sz;
  logic        g, w, r, pend, en_e, we_e, rd_acc, push;
  logic [11:0] a_e;
  logic [7:0]  d_e;
  logic [19:0] hd;

  initial begin
    for (int i = 0; i < 4096; i++) mm[i] = pat(i);
    m_rd_pend = 0; m_rvalid = 0; m_rd_addr = 0; m_rd_val = 0; m_gdata = 0;
    m_cpu_rdata = 0; m_flight = 0; m_starve = 0;
    forever begin
      @(negedge clk_gpu);
      if (rst) begin
        chk("reset_outputs",
            {bus.gpu_gnt_o, bus.gpu_rvalid_o, bus.gpu_rdata_o, bus.cpu_wfull_o,
             bus.cpu_rbusy_o, bus.cpu_rdone_o, bus.cpu_rdata_o, bus.vram_en_o,
             bus.vram_we_o, bus.vram_addr_o, bus.vram_wdata_o}, 64'd0);
        wq.delete();
        m_rd_pend = 0; m_rvalid = 0; m_gdata = 0; m_cpu_rdata = 0;
        m_flight = 0; m_starve = 0;
      end else begin
        sz   = wq.size();
        pend = (sz != 0) || m_rd_pend;
        g    = bus.gpu_req_i && (m_starve < STARVE_LIMIT);
        w    = !g && (sz != 0);
        r    = !g && (sz == 0) && m_rd_pend;
        hd   = (sz != 0) ? wq[0] : 20'h0;
        en_e = 0; we_e = 0; a_e = 0; d_e = 0;
        if (g && bus.gpu_addr_i < 12'h900) begin
          en_e = 1; a_e = bus.gpu_addr_i;
        end else if (w && hd[19:8] < 12'h900) begin
          en_e = 1; we_e = 1; a_e = hd[19:8]; d_e = hd[7:0];
        end else if (r && m_rd_addr < 12'h900) begin
          en_e = 1; a_e = m_rd_addr;
        end

        chk("gpu_gnt", bus.gpu_gnt_o, g);
        chk("gpu_rvalid", bus.gpu_rvalid_o, m_rvalid);
        if (m_rvalid) chk("gpu_rdata", bus.gpu_rdata_o, m_gdata);
        chk("cpu_wfull", bus.cpu_wfull_o, sz == WR_FIFO_DEPTH);
        chk("cpu_rbusy", bus.cpu_rbusy_o, m_rd_pend || (m_flight == 2));
        chk("cpu_rdone", bus.cpu_rdone_o, m_flight == 1);
        chk("cpu_rdata", bus.cpu_rdata_o, m_cpu_rdata);
        chk("vram_en", bus.vram_en_o, en_e);
        chk("vram_we", bus.vram_we_o, we_e);
        if (en_e) chk("vram_addr", bus.vram_addr_o, a_e);
        if (we_e) chk("vram_wdata", bus.vram_wdata_o, d_e);

        rd_acc = bus.cpu_rd_i && !m_rd_pend && (m_flight != 2);
        if (m_flight == 2) m_cpu_rdata = m_rd_val;
        if (m_flight != 0) m_flight--;
        if (r) begin
          m_rd_pend = 0;
          m_flight  = 2;
          m_rd_val  = (m_rd_addr < 12'h900) ? mm[m_rd_addr] : 8'h00;
        end
        if (rd_acc) begin
          m_rd_pend = 1;
          m_rd_addr = bus.cpu_raddr_i;
        end
        m_rvalid = g;
        if (g) m_gdata = (bus.gpu_addr_i < 12'h900) ? mm[bus.gpu_addr_i] : 8'h00;
        push = bus.cpu_wr_i && ((sz < WR_FIFO_DEPTH) || w);
        if (w) begin
          if (hd[19:8] < 12'h900) mm[hd[19:8]] = hd[7:0];
          void'(wq.pop_front());
        end
        if (push) wq.push_back({bus.cpu_waddr_i, bus.cpu_wdata_i});
        if (w || r || !pend) m_starve = 0;
        else if (g && m_starve < STARVE_LIMIT) m_starve++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_gpu);
    #1;
  endtask

  task automatic cpu_write(input logic [11:0] a, input logic [7:0] d);
    bus.cpu_wr_i = 1; bus.cpu_waddr_i = a; bus.cpu_wdata_i = d;
    cyc(1);
    bus.cpu_wr_i = 0;
  endtask

  int gcnt, gap, vz, encnt, dncnt;

  initial begin
    n_chk = 0; n_err = 0;
    rst = 0;
    bus.gpu_req_i = 0; bus.gpu_addr_i = 0;
    bus.cpu_wr_i = 0; bus.cpu_waddr_i = 0; bus.cpu_wdata_i = 0;
    bus.cpu_rd_i = 0; bus.cpu_raddr_i = 0;
    #2 rst = 1;
    cyc(2);
    rst = 0;
    cyc(1);

    // Write then read back 0x123
    cpu_write(12'h123, 8'hA5);
    cyc(1);
    bus.cpu_rd_i = 1; bus.cpu_raddr_i = 12'h123;
    cyc(1);
    bus.cpu_rd_i = 0;
    chk("t1_read_grant", {bus.vram_en_o, bus.vram_we_o, bus.vram_addr_o}, {2'b10, 12'h123});
    cyc(1);
    chk("t1_data_cycle", {bus.cpu_rbusy_o, bus.cpu_rdone_o}, 2'b10);
    cyc(1);
    chk("t1_rdone", {bus.cpu_rbusy_o, bus.cpu_rdone_o}, 2'b01);
    chk("t1_rdata", bus.cpu_rdata_o, 8'hA5);
    chk("t1_vmem", vmem[12'h123], 8'hA5);

    // Continuous GPU traffic with one queued write
    gcnt = 0; gap = -1; vz = 0;
    for (int i = 0; i < 20; i++) begin
      bus.gpu_req_i = 1; bus.gpu_addr_i = 12'(i * 3);
      bus.cpu_wr_i = (i == 0); bus.cpu_waddr_i = 12'h400; bus.cpu_wdata_i = 8'h42;
      @(negedge clk_gpu);
      if (bus.gpu_gnt_o) gcnt++;
      else if (gap < 0) gap = i;
      if (i > 0 && !bus.gpu_rvalid_o) vz++;
      cyc(1);
    end
    bus.gpu_req_i = 0; bus.cpu_wr_i = 0;
    chk("t2_gnt_count", gcnt, 19);
    chk("t2_gap_cycle", gap, 9);
    chk("t2_rvalid_gaps", vz, 1);
    cyc(2);
    chk("t2_vmem", vmem[12'h400], 8'h42);

    // Five back-to-back writes under GPU pressure
    for (int i = 0; i < 5; i++) begin
      bus.gpu_req_i = 1; bus.gpu_addr_i = 12'h100;
      bus.cpu_wr_i = 1; bus.cpu_waddr_i = 12'(12'h200 + i); bus.cpu_wdata_i = 8'(8'h10 + i);
      cyc(1);
      if (i == 2) chk("t3_wfull_3", bus.cpu_wfull_o, 1'b0);
      if (i == 3) chk("t3_wfull_4", bus.cpu_wfull_o, 1'b1);
    end
    bus.cpu_wr_i = 0;
    cyc(12);
    bus.gpu_req_i = 0;
    cyc(10);
    for (int k = 0; k < 4; k++) chk("t3_vmem", vmem[12'h200 + k], 8'(8'h10 + k));
    chk("t3_dropped", vmem[12'h204], pat(12'h204));

    // Read immediately after a posted write to the same address
    cpu_write(12'h010, 8'h3C);
    bus.cpu_rd_i = 1; bus.cpu_raddr_i = 12'h010;
    cyc(1);
    bus.cpu_rd_i = 0;
    cyc(4);
    chk("t4_rdata", bus.cpu_rdata_o, 8'h3C);

    // Out-of-range accesses
    bus.gpu_req_i = 1; bus.gpu_addr_i = 12'h900;
    #1;
    chk("t5_gnt_oob", {bus.gpu_gnt_o, bus.vram_en_o}, 2'b10);
    cyc(1);
    bus.gpu_req_i = 0;
    chk("t5_rvalid_oob", {bus.gpu_rvalid_o, bus.gpu_rdata_o}, {1'b1, 8'h00});
    cpu_write(12'h900, 8'hEE);
    cyc(3);
    chk("t5_vmem_8ff", vmem[12'h8FF], pat(12'h8FF));
    chk("t5_vmem_900", vmem[12'h900], pat(12'h900));
    bus.cpu_rd_i = 1; bus.cpu_raddr_i = 12'h900;
    cyc(1);
    bus.cpu_rd_i = 0;
    cyc(4);
    chk("t5_cpu_rd_oob", bus.cpu_rdata_o, 8'h00);

    // Reset while a read waits behind two posted writes
    bus.gpu_req_i = 1; bus.gpu_addr_i = 12'h050;
    cpu_write(12'h300, 8'h99);
    cpu_write(12'h301, 8'h98);
    bus.cpu_rd_i = 1; bus.cpu_raddr_i = 12'h300;
    cyc(1);
    bus.cpu_rd_i = 0;
    cyc(1);
    chk("t6_pending", {bus.cpu_rbusy_o, bus.cpu_wfull_o}, 2'b10);
    #2 rst = 1;
    #1;
    chk("t6_async_zero",
        {bus.gpu_gnt_o, bus.gpu_rvalid_o, bus.gpu_rdata_o, bus.cpu_wfull_o,
         bus.cpu_rbusy_o, bus.cpu_rdone_o, bus.cpu_rdata_o, bus.vram_en_o,
         bus.vram_we_o, bus.vram_addr_o, bus.vram_wdata_o}, 64'd0);
    bus.gpu_req_i = 0;
    cyc(2);
    rst = 0;
    chk("t6_after_release", {bus.cpu_wfull_o, bus.cpu_rbusy_o}, 2'b00);
    encnt = 0; dncnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_gpu);
      if (bus.vram_en_o) encnt++;
      if (bus.cpu_rdone_o) dncnt++;
    end
    chk("t6_no_access", encnt, 0);
    chk("t6_no_rdone", dncnt, 0);
    chk("t6_vmem_300", vmem[12'h300], pat(12'h300));
    chk("t6_vmem_301", vmem[12'h301], pat(12'h301));

    cyc(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
